// File: rtl/n64adv_vout_align_if.sv
// Colour, sync and output-setting bundle between the colour converter and the output aligner.
interface n64adv_vout_align_if #(
    parameter int COLOR_W  = 8,
    parameter int CHANNELS = 3
);
    logic [CHANNELS*COLOR_W-1:0] vdata_i;
    logic [3:0]                  sync_i;
    logic [3:0]                  dly_sel_i;
    logic                        swap_rb_i;
    logic                        sog_en_i;
    logic [2:0]                  filter_i;
    logic [1:0]                  linemult_i;
    logic                        use_vga_i;

    logic [CHANNELS*COLOR_W-1:0] vdata_o;
    logic [1:0]                  nCSYNC_o;
    logic                        nVSYNC_or_F2;
    logic                        nHSYNC_or_F1;
    logic [3:0]                  dly_active_o;
    logic                        frame_lock_o;

    modport master (
        output vdata_i, sync_i, dly_sel_i, swap_rb_i, sog_en_i, filter_i, linemult_i, use_vga_i,
        input  vdata_o, nCSYNC_o, nVSYNC_or_F2, nHSYNC_or_F1, dly_active_o, frame_lock_o
    );

    modport slave (
        input  vdata_i, sync_i, dly_sel_i, swap_rb_i, sog_en_i, filter_i, linemult_i, use_vga_i,
        output vdata_o, nCSYNC_o, nVSYNC_or_F2, nHSYNC_or_F1, dly_active_o, frame_lock_o
    );
endinterface

// File: rtl/n64adv_vout_align.sv
// Output alignment/sync stage: frame-synchronous colour delay, R/B swap, CSYNC/SOG, shared VGA/filter pins, vsync watchdog.
// Define VOUT_SYNC_ALIGN_EN to route the sync bits through a delay line matched to the colour tap.
module n64adv_vout_align #(
    parameter int COLOR_W  = 8,
    parameter int CHANNELS = 3,
    parameter int MAX_DLY  = 4,
    parameter int WD_W     = 20
) (
    input  logic               VCLK_Tx,
    input  logic               VRST_Tx,
    n64adv_vout_align_if.slave vout
);
    localparam int         DATA_W    = CHANNELS * COLOR_W;
    localparam logic [3:0] MAX_DLY_L = 4'(MAX_DLY);

    typedef logic [DATA_W-1:0] word_t;

    word_t           vdata_q, vdata_d;
    logic [3:0]      sync_q;
    logic            nvsync_prev_q;
    word_t           dly_line_q [MAX_DLY:1];
    logic [3:0]      dly_shadow_q, dly_shadow_d;
    logic [1:0]      filt_shadow_q, filt_shadow_d;
    logic [3:0]      dly_active_q;
    logic [1:0]      filt_q;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            lock_q, lock_d;
    word_t           vdata_o_q;
    logic [1:0]      csync_o_q;
    logic            vs_pin_q, hs_pin_q;
    logic            fev, wd_expire, apply;
    word_t           tap_sel;
    logic [3:0]      sync_sel;

    function automatic word_t swap_ends(input word_t w);
        word_t r;
        r = w;
        r[DATA_W-1 -: COLOR_W] = w[COLOR_W-1:0];
        r[COLOR_W-1:0]         = w[DATA_W-1 -: COLOR_W];
        return r;
    endfunction

    assign fev       = nvsync_prev_q & ~sync_q[3];
    assign wd_expire = (wd_q == '1);
    assign apply     = fev | wd_expire;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        vdata_d       = vout.swap_rb_i ? swap_ends(vout.vdata_i) : vout.vdata_i;
        dly_shadow_d  = (vout.dly_sel_i > MAX_DLY_L) ? MAX_DLY_L : vout.dly_sel_i;
        filt_shadow_d = (vout.filter_i == 3'd0) ? vout.linemult_i : vout.filter_i[1:0] - 2'd1;
        wd_d          = wd_q + 1'b1;
        lock_d        = lock_q;
        // A frame event outranks a simultaneous watchdog expiry.
        if (fev) begin
            wd_d   = '0;
            lock_d = 1'b1;
        end else if (wd_expire) begin
            wd_d   = '0;
            lock_d = 1'b0;
        end
    end

    always_comb begin
        tap_sel = vdata_q;
        for (int k = 1; k <= MAX_DLY; k++)
            if (dly_active_q == 4'(k)) tap_sel = dly_line_q[k];
    end

`ifdef VOUT_SYNC_ALIGN_EN
    logic [3:0] sync_line_q [MAX_DLY:1];

    always_comb begin
        sync_sel = sync_q;
        for (int k = 1; k <= MAX_DLY; k++)
            if (dly_active_q == 4'(k)) sync_sel = sync_line_q[k];
    end

    always_ff @(posedge VCLK_Tx or posedge VRST_Tx) begin
        if (VRST_Tx) begin
            for (int k = 1; k <= MAX_DLY; k++) sync_line_q[k] <= '0;
        end else begin
            sync_line_q[1] <= sync_q;
            for (int k = 2; k <= MAX_DLY; k++) sync_line_q[k] <= sync_line_q[k-1];
        end
    end
`else
    always_comb sync_sel = sync_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge VCLK_Tx or posedge VRST_Tx) begin
        if (VRST_Tx) begin
            vdata_q       <= '0;
            sync_q        <= '0;
            nvsync_prev_q <= 1'b0;
            // NOTE: the delay line is reset too, so no stale pixels leak out after reset.
            for (int k = 1; k <= MAX_DLY; k++) dly_line_q[k] <= '0;
            dly_shadow_q  <= '0;
            filt_shadow_q <= '0;
            dly_active_q  <= '0;
            filt_q        <= '0;
            wd_q          <= '0;
            lock_q        <= 1'b0;
            vdata_o_q     <= '0;
            csync_o_q     <= '0;
            vs_pin_q      <= 1'b0;
            hs_pin_q      <= 1'b0;
        end else begin
            vdata_q       <= vdata_d;
            sync_q        <= vout.sync_i;
            nvsync_prev_q <= sync_q[3];
            dly_line_q[1] <= vdata_q;
            for (int k = 2; k <= MAX_DLY; k++) dly_line_q[k] <= dly_line_q[k-1];
            dly_shadow_q  <= dly_shadow_d;
            filt_shadow_q <= filt_shadow_d;
            wd_q          <= wd_d;
            lock_q        <= lock_d;
            if (apply) begin
                dly_active_q <= dly_shadow_q;
                filt_q       <= filt_shadow_q;
            end
            vdata_o_q <= tap_sel;
            csync_o_q <= {sync_sel[0], vout.sog_en_i & sync_sel[0]};
            vs_pin_q  <= vout.use_vga_i ? sync_sel[3] : filt_q[1];
            hs_pin_q  <= vout.use_vga_i ? sync_sel[1] : filt_q[0];
        end
    end

    assign vout.vdata_o      = vdata_o_q;
    assign vout.nCSYNC_o     = csync_o_q;
    assign vout.nVSYNC_or_F2 = vs_pin_q;
    assign vout.nHSYNC_or_F1 = hs_pin_q;
    assign vout.dly_active_o = dly_active_q;
    assign vout.frame_lock_o = lock_q;
endmodule

// File: tb/tb_n64adv_vout_align.sv
// Bench for n64adv_vout_align: history-based reference model checked every cycle, plus vector table and corner sequences.
module tb_n64adv_vout_align;
    localparam int COLOR_W  = 8;
    localparam int CHANNELS = 3;
    localparam int MAX_DLY  = 4;
    localparam int WD_W     = 4;
    localparam int WD_MAX   = (1 << WD_W) - 1;
    localparam int HN       = 8192;
`ifdef VOUT_SYNC_ALIGN_EN
    localparam bit SYNC_ALIGN = 1'b1;
`else
    localparam bit SYNC_ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] vdata;
        logic [3:0]  sync;
        logic [3:0]  dly;
        logic        swap;
        logic        sog;
        logic [2:0]  filt;
        logic [1:0]  lm;
        logic        vga;
    } in_t;

    typedef struct packed {
        logic [23:0] vdata;
        logic        swap;
        logic        sog;
        logic [2:0]  filt;
        logic [1:0]  lm;
        logic        vga;
        logic [23:0] exp_vdata;
        logic [1:0]  exp_pins;
        logic [1:0]  exp_cs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    n64adv_vout_align_if #(.COLOR_W(COLOR_W), .CHANNELS(CHANNELS)) vif ();

    n64adv_vout_align #(
        .COLOR_W(COLOR_W), .CHANNELS(CHANNELS), .MAX_DLY(MAX_DLY), .WD_W(WD_W)
    ) dut (
        .VCLK_Tx(clk),
        .VRST_Tx(rst),
        .vout   (vif)
    );

    in_t hist [HN];
    int  m_dly  [HN];
    int  m_filt [HN];
    int  m_wd   [HN];
    bit  m_lock [HN];
    bit  m_fev  [HN];
    int  n = 0, base = 0;
    int  total = 0, bad = 0;
    in_t cur;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Inputs registered at edge k; anything at or before the last reset reads as zero.
    function automatic in_t hin(input int k);
        if (k <= base) return '0;
        return hist[k];
    endfunction

    function automatic logic [23:0] swapped(input in_t x);
        logic [23:0] v;
        v = x.vdata;
        return x.swap ? {v[7:0], v[15:8], v[23:16]} : v;
    endfunction

    function automatic int filt_of(input in_t x);
        if (x.filt == 3'd0) return int'(x.lm);
        return (int'(x.filt[1:0]) + 3) % 4;
    endfunction

    task automatic model_and_check();
        in_t         prev, src, now;
        bit          wd_fire, apply;
        int          d_prev;
        logic [3:0]  s;
        logic [1:0]  fb;
        logic [23:0] e_vd;
        prev    = hin(n - 1);
        now     = hin(n);
        wd_fire = (m_wd[n-1] == WD_MAX);
        apply   = m_fev[n-1] || wd_fire;
        d_prev  = m_dly[n-1];
        m_fev[n]  = prev.sync[3] && !now.sync[3];
        m_wd[n]   = apply ? 0 : m_wd[n-1] + 1;
        m_lock[n] = m_fev[n-1] ? 1'b1 : (wd_fire ? 1'b0 : m_lock[n-1]);
        m_dly[n]  = apply ? ((int'(prev.dly) > MAX_DLY) ? MAX_DLY : int'(prev.dly)) : m_dly[n-1];
        m_filt[n] = apply ? filt_of(prev) : m_filt[n-1];
        src  = hin(n - 1 - d_prev);
        e_vd = swapped(src);
        s    = SYNC_ALIGN ? src.sync : prev.sync;
        fb   = 2'(m_filt[n-1]);
        check("vdata_o", 32'(vif.vdata_o), 32'(e_vd));
        check("nCSYNC_o", 32'(vif.nCSYNC_o), 32'({s[0], now.sog & s[0]}));
        check("nVSYNC_or_F2", 32'(vif.nVSYNC_or_F2), 32'(now.vga ? s[3] : fb[1]));
        check("nHSYNC_or_F1", 32'(vif.nHSYNC_or_F1), 32'(now.vga ? s[1] : fb[0]));
        check("dly_active_o", 32'(vif.dly_active_o), 32'(m_dly[n]));
        check("frame_lock_o", 32'(vif.frame_lock_o), 32'(m_lock[n]));
    endtask

    task automatic drive(input in_t x);
        vif.vdata_i    = x.vdata;
        vif.sync_i     = x.sync;
        vif.dly_sel_i  = x.dly;
        vif.swap_rb_i  = x.swap;
        vif.sog_en_i   = x.sog;
        vif.filter_i   = x.filt;
        vif.linemult_i = x.lm;
        vif.use_vga_i  = x.vga;
    endtask

    // Called at a falling edge: apply cur, clock once, compare everything against the model.
    task automatic step();
        drive(cur);
        hist[n+1] = cur;
        @(posedge clk);
        #1;
        n++;
        model_and_check();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vdata"}, 32'(vif.vdata_o), 32'd0);
        check({tag, "_csync"}, 32'(vif.nCSYNC_o), 32'd0);
        check({tag, "_pins"}, 32'({vif.nVSYNC_or_F2, vif.nHSYNC_or_F1}), 32'd0);
        check({tag, "_dly"}, 32'(vif.dly_active_o), 32'd0);
        check({tag, "_lock"}, 32'(vif.frame_lock_o), 32'd0);
    endtask

    task automatic mark_reset_release();
        base = n;
        m_dly[n] = 0; m_filt[n] = 0; m_wd[n] = 0; m_lock[n] = 1'b0; m_fev[n] = 1'b0;
    endtask

    // Asynchronous reset in the middle of a clock period.
    task automatic reset_mid();
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mark_reset_release();
    endtask

    task automatic frame_event(input int hi, input int lo);
        cur.sync[3] = 1'b1;
        repeat (hi) step();
        cur.sync[3] = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  waited;
        bit  seen;
        int  gap, low;

        vecs[0] = '{24'hFF8010, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 24'h1080FF, 2'b10, 2'b10};
        vecs[1] = '{24'hFF8010, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0, 24'hFF8010, 2'b11, 2'b11};
        vecs[2] = '{24'h123456, 1'b1, 1'b1, 3'd1, 2'd3, 1'b0, 24'h563412, 2'b00, 2'b11};
        vecs[3] = '{24'hABCDEF, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 24'hABCDEF, 2'b01, 2'b10};
        vecs[4] = '{24'h00FF00, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 24'h00FF00, 2'b01, 2'b10};
        vecs[5] = '{24'h010203, 1'b1, 1'b0, 3'd7, 2'd0, 1'b0, 24'h030201, 2'b10, 2'b10};
        vecs[6] = '{24'hC0FFEE, 1'b0, 1'b1, 3'd3, 2'd0, 1'b1, 24'hC0FFEE, 2'b01, 2'b11};
        vecs[7] = '{24'h5A0000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 24'h00005A, 2'b00, 2'b10};

        cur = '0;
        cur.sync = 4'hF;
        drive(cur);
        repeat (2) @(negedge clk);
        check_all_zero("rst_init");
        rst = 1'b0;
        mark_reset_release();

        // Latency 2 with dly_sel_i = 0.
        repeat (3) step();
        cur.vdata = 24'hA5C35A;
        step();
        cur.vdata = 24'h000000;
        step();
        check("lat2_vdata", 32'(vif.vdata_o), 32'h00A5C35A);

        // Mid-frame delay request waits for the vsync falling edge.
        cur.dly = 4'd2;
        repeat (5) step();
        check("dly_midframe", 32'(vif.dly_active_o), 32'd0);
        cur.sync[3] = 1'b0;
        step();
        check("dly_at_fev", 32'(vif.dly_active_o), 32'd0);
        step();
        check("dly_after_fev", 32'(vif.dly_active_o), 32'd2);
        cur.vdata   = 24'h3C3C3C;
        cur.sync[0] = 1'b0;
        step();
        cur.vdata   = 24'h000000;
        cur.sync[0] = 1'b1;
        step();
        check("sync_lat_e2", 32'(vif.nCSYNC_o[1]), 32'(SYNC_ALIGN ? 1'b1 : 1'b0));
        check("sog_off_e2", 32'(vif.nCSYNC_o[0]), 32'd0);
        step();
        step();
        check("lat4_vdata", 32'(vif.vdata_o), 32'h003C3C3C);
        check("sync_lat_e4", 32'(vif.nCSYNC_o[1]), 32'(SYNC_ALIGN ? 1'b0 : 1'b1));
        check("sog_off_e4", 32'(vif.nCSYNC_o[0]), 32'd0);

        // Clamp to MAX_DLY.
        cur.dly = 4'd9;
        frame_event(2, 2);
        check("dly_clamp", 32'(vif.dly_active_o), 32'd4);

        // Vector table: steady settings applied through one frame event.
        foreach (vecs[i]) begin
            cur.vdata = vecs[i].vdata;
            cur.swap  = vecs[i].swap;
            cur.sog   = vecs[i].sog;
            cur.filt  = vecs[i].filt;
            cur.lm    = vecs[i].lm;
            cur.vga   = vecs[i].vga;
            cur.dly   = 4'd0;
            cur.sync  = 4'hF;
            frame_event(3, 6);
            check($sformatf("vec%0d_vdata", i), 32'(vif.vdata_o), 32'(vecs[i].exp_vdata));
            check($sformatf("vec%0d_pins", i), 32'({vif.nVSYNC_or_F2, vif.nHSYNC_or_F1}), 32'(vecs[i].exp_pins));
            check($sformatf("vec%0d_csync", i), 32'(vif.nCSYNC_o), 32'(vecs[i].exp_cs));
            check($sformatf("vec%0d_lock", i), 32'(vif.frame_lock_o), 32'd1);
        end

        // Watchdog: no vsync edge, settings still land and lock drops.
        cur.sync = 4'hF;
        cur.vga  = 1'b0;
        cur.dly  = 4'd3;
        seen     = 1'b0;
        waited   = 0;
        while (!seen && waited < 40) begin
            step();
            waited++;
            if (vif.dly_active_o == 4'd3) seen = 1'b1;
        end
        check("wd_applied", 32'(seen), 32'd1);
        check("wd_lock_low", 32'(vif.frame_lock_o), 32'd0);
        frame_event(1, 2);
        check("wd_relock", 32'(vif.frame_lock_o), 32'd1);

        // Randomised traffic with occasional long frames and one mid-stream reset.
        gap = 8;
        low = 0;
        for (int i = 0; i < 2500; i++) begin
            cur.vdata     = 24'($urandom);
            cur.sync[2:0] = 3'($urandom);
            if (low > 0) begin
                cur.sync[3] = 1'b0;
                low--;
            end else if (gap > 0) begin
                cur.sync[3] = 1'b1;
                gap--;
            end else begin
                cur.sync[3] = 1'b0;
                low = $urandom_range(3, 0);
                gap = $urandom_range(30, 3);
            end
            if ($urandom_range(7, 0) == 0) cur.dly  = 4'($urandom);
            if ($urandom_range(7, 0) == 0) cur.filt = 3'($urandom);
            if ($urandom_range(7, 0) == 0) cur.lm   = 2'($urandom_range(2, 0));
            if ($urandom_range(15, 0) == 0) cur.swap = 1'($urandom);
            if ($urandom_range(15, 0) == 0) cur.sog  = 1'($urandom);
            if ($urandom_range(15, 0) == 0) cur.vga  = 1'($urandom);
            step();
            if (i == 1200) reset_mid();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
